// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NOR) among NREQ
// requesters, with a one-entry registered response stage tagged by the winner index.
//
// state | meaning
// EMPTY | response register holds nothing; slot is free
// FULL  | response register valid; rsp_y/rsp_id held until rsp_ready
module logic_op_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*2-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_y,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]   rsp_y_q;
    logic [IDW-1:0] rsp_id_q;
    logic [IDW-1:0] win_id;
    logic           found;
    logic           slot_free;
    logic           grant;
    logic [W-1:0]   op_y;

    logic [W-1:0]   a_arr  [NREQ];
    logic [W-1:0]   b_arr  [NREQ];
    logic [1:0]     op_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[i*W +: W];
        assign b_arr[i]  = req_b[i*W +: W];
        assign op_arr[i] = req_op[i*2 +: 2];
    end

    // Search order starts at rr_ptr and wraps modulo NREQ (NREQ need not be a power of two).
    always_comb begin
        int             sum;
        logic [IDW-1:0] cand;
        sum    = 0;
        cand   = '0;
        found  = 1'b0;
        win_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = int'(rr_ptr_q) + k;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            cand = IDW'(sum);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

    assign slot_free = (state_q == EMPTY) || rsp_ready;
    // Reset gates the grant so no request is consumed while the block is held in reset.
    assign grant     = !reset && slot_free && found;

    always_comb begin
        unique case (op_arr[win_id])
            2'b00:   op_y = a_arr[win_id] & b_arr[win_id];
            2'b01:   op_y = a_arr[win_id] | b_arr[win_id];
            2'b10:   op_y = a_arr[win_id] ^ b_arr[win_id];
            default: op_y = ~(a_arr[win_id] | b_arr[win_id]);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        req_ready = '0;
        if (grant) begin
            req_ready[win_id] = 1'b1;
            state_d           = FULL;
            if (win_id == IDW'(NREQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_id + IDW'(1);
            end
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            rsp_y_q  <= '0;
            rsp_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (grant) begin
                rsp_y_q  <= op_y;
                rsp_id_q <= win_id;
            end
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = rsp_valid || (|req_valid);

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the arbitration and response slot.
module tb_logic_op_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*2-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_y;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    logic_op_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        req_op[i*2 +: 2] = op;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
    endtask

    function automatic logic [W-1:0] exp_of(input int i);
        return ref_op(req_op[i*2 +: 2], req_a[i*W +: W], req_b[i*W +: W]);
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 2'(i), $urandom, $urandom);
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid);
        end
        vectors++;
        if (rsp_y !== '0 || rsp_id !== '0) begin
            miscompares++; $display("FAIL reset_rsp_data: got y=%h id=%0d expected 0/0", rsp_y, rsp_id);
        end
        vectors++;
        if (req_ready !== '0) begin
            miscompares++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        req_valid = '0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        set_req(2, 2'b01, 32'h0000FFFF, 32'hFF000000);
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++; $display("FAIL single_grant: got %b expected 0100", req_ready);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_y !== 32'hFF00FFFF || rsp_id !== 2'd2) begin
            miscompares++;
            $display("FAIL single_rsp: got v=%0b y=%h id=%0d expected 1 ff00ffff 2", rsp_valid, rsp_y, rsp_id);
        end
        req_valid = '0;
    endtask

    task automatic test_ops();
        logic [W-1:0] exp_tab [4];
        exp_tab[0] = 32'hF000F000;
        exp_tab[1] = 32'hFFF0FFF0;
        exp_tab[2] = 32'h0FF00FF0;
        exp_tab[3] = 32'h000F000F;
        rsp_ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_y !== exp_tab[k-1] || rsp_id !== 2'd0) begin
                    miscompares++;
                    $display("FAIL ops_op%0d: got v=%0b y=%h id=%0d expected 1 %h 0", k-1,
                             rsp_valid, rsp_y, rsp_id, exp_tab[k-1]);
                end
            end
            if (k < 4) begin
                req_valid = 4'b0001;
                set_req(0, 2'(k), 32'hF0F0F0F0, 32'hFF00FF00);
                #1;
                vectors++;
                if (req_ready !== 4'b0001) begin
                    miscompares++; $display("FAIL ops_grant%0d: got %b expected 0001", k, req_ready);
                end
            end else begin
                req_valid = '0;
            end
        end
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 3, 0, 1};
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_req(i, 2'($urandom_range(0, 3)), $urandom, $urandom);
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL rr_grant0: got %b expected 0001", req_ready);
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(order[c-1]) || rsp_y !== exp_of(order[c-1])) begin
                miscompares++;
                $display("FAIL rr_rsp%0d: got v=%0b id=%0d y=%h expected 1 %0d %h", c-1, rsp_valid,
                         rsp_id, rsp_y, order[c-1], exp_of(order[c-1]));
            end
            if (c < 6) begin
                #1;
                vectors++;
                if (req_ready !== (4'b0001 << order[c])) begin
                    miscompares++;
                    $display("FAIL rr_grant%0d: got %b expected %b", c, req_ready, 4'b0001 << order[c]);
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] y_hold;
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        set_req(1, 2'b10, $urandom, $urandom);
        set_req(3, 2'b11, $urandom, $urandom);
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++; $display("FAIL bp_first_grant: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        y_hold    = exp_of(1);
        rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y !== y_hold || req_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL bp_stall%0d: got v=%0b id=%0d y=%h rdy=%b expected 1 1 %h 0000", c,
                         rsp_valid, rsp_id, rsp_y, req_ready, y_hold);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++; $display("FAIL bp_release_grant: got %b expected 1000", req_ready);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_y !== exp_of(3)) begin
            miscompares++;
            $display("FAIL bp_release_rsp: got v=%0b id=%0d y=%h expected 1 3 %h", rsp_valid, rsp_id,
                     rsp_y, exp_of(3));
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = '1;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #2;
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_full: got %0b expected 1", rsp_valid);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstmid_async: got v=%0b rdy=%b expected 0 0000", rsp_valid, req_ready);
        end
        @(negedge clk);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL rstmid_first_grant: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
            miscompares++; $display("FAIL rstmid_rsp: got v=%0b id=%0d expected 1 0", rsp_valid, rsp_id);
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        bit           m_full;
        logic [W-1:0] m_y;
        int           m_id;
        int           m_ptr;
        int           m_win;
        int           waits [NREQ];
        int           worst;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset  = 1'b0;
        m_full = 1'b0;
        m_y    = '0;
        m_id   = 0;
        m_ptr  = 0;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            vectors++;
            if (rsp_valid !== m_full || (m_full && (rsp_y !== m_y || rsp_id !== IDW'(m_id)))) begin
                miscompares++;
                $display("FAIL rand_rsp cyc %0d: got v=%0b y=%h id=%0d expected %0b %h %0d", cyc,
                         rsp_valid, rsp_y, rsp_id, m_full, m_y, m_id);
            end
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom_range(0, 99) < 65);
                set_req(i, 2'($urandom_range(0, 3)), $urandom, $urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            m_win = -1;
            if (!m_full || rsp_ready) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_win < 0 && req_valid[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
                end
            end
            exp_ready = (m_win >= 0) ? (4'b0001 << m_win) : 4'b0000;
            vectors++;
            if (req_ready !== exp_ready || busy !== (m_full || (|req_valid))) begin
                miscompares++;
                $display("FAIL rand_grant cyc %0d: got rdy=%b busy=%0b expected %b %0b", cyc,
                         req_ready, busy, exp_ready, m_full || (|req_valid));
            end
            worst = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || m_win == i) waits[i] = 0;
                else if (m_win >= 0) waits[i]++;
                if (waits[i] > worst) worst = waits[i];
            end
            vectors++;
            if (worst >= NREQ) begin
                miscompares++;
                $display("FAIL rand_fairness cyc %0d: got wait %0d grants expected < %0d", cyc, worst, NREQ);
            end
            if (m_win >= 0) begin
                m_full = 1'b1;
                m_y    = exp_of(m_win);
                m_id   = m_win;
                m_ptr  = (m_win + 1) % NREQ;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        req_a  = '0;
        req_b  = '0;
        req_op = '0;
        test_reset();
        test_single();
        test_ops();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish before 2000000");
        $fatal(1, "timeout");
    end

endmodule
